cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_pkg.sv | 33 +++
 rtl/cmd_wdog.sv | 34 +++
 rtl/cmd_dispatch.sv | 164 ++++++++++++++++
 tb/tb_cmd_dispatch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command dispatcher.
package cmd_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned HDG_W  = 12;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned SQ_W   = 4;
  localparam int unsigned TMO_W  = 24;

  typedef enum logic [3:0] {
    OP_CAL  = 4'h0,
    OP_MOVE = 4'h2
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_CAL,
    S_WAIT_MOVE,
    S_RESP
  } state_t;

  localparam logic [RESP_W-1:0] RESP_ACK = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_ERR = 8'hEE;
  localparam logic [RESP_W-1:0] RESP_TMO = 8'hDD;

  // Heading field shifted left and truncated to the heading width.
  function automatic logic [HDG_W-1:0] heading_of(input logic [7:0] fld,
                                                  input int unsigned sh);
    return HDG_W'(32'(fld) << sh);
  endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Per-command watchdog counter; present only when CMD_TIMEOUT_EN is defined.
`ifdef CMD_TIMEOUT_EN
module cmd_wdog
  import cmd_pkg::*;
#(
  parameter logic [TMO_W-1:0] LIMIT = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LIMIT - TMO_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes CAL/MOVE commands, tracks completion, sends a response byte.
// Optional per-command timeout is enabled with the CMD_TIMEOUT_EN macro.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int unsigned HDG_SHIFT      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        cal_done,
  input  logic        sq_done,
  input  logic        tx_busy,
  output logic        strt_cal,
  output logic        move_go,
  output logic [11:0] desired_heading,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic        busy
);

  // A zero timeout has no meaningful last count.
  if (TIMEOUT_CYCLES == 24'd0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [SQ_W-1:0]     sq_cnt_q, sq_cnt_d;
  logic [HDG_W-1:0]    hdg_q, hdg_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic                clr_q, clr_d;
  logic                strt_q, strt_d;
  logic                move_go_q, move_go_d;
  logic                send_q, send_d;
  logic                busy_q, busy_d;
  logic                tmo_hit;

`ifdef CMD_TIMEOUT_EN
  logic wd_clr, wd_en;

  assign wd_clr = (state_q == S_DECODE);
  assign wd_en  = (state_q == S_WAIT_CAL) || (state_q == S_WAIT_MOVE);

  cmd_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    sq_cnt_d = sq_cnt_q;
    hdg_d    = hdg_q;
    resp_d   = resp_q;
    clr_d    = 1'b0;
    strt_d   = 1'b0;
    send_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          cmd_d   = cmd;
          clr_d   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cmd_q[15:12])
          OP_CAL: begin
            strt_d  = 1'b1;
            state_d = S_WAIT_CAL;
          end
          OP_MOVE: begin
            sq_cnt_d = cmd_q[3:0];
            hdg_d    = heading_of(cmd_q[11:4], HDG_SHIFT);
            if (cmd_q[3:0] != SQ_W'(0)) begin
              state_d = S_WAIT_MOVE;
            end else begin
              state_d = S_RESP;
              resp_d  = RESP_ACK;
            end
          end
          default: begin
            state_d = S_RESP;
            resp_d  = RESP_ERR;
          end
        endcase
      end
      S_WAIT_CAL: begin
        if (cal_done) begin
          state_d = S_RESP;
          resp_d  = RESP_ACK;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          resp_d  = RESP_TMO;
        end
      end
      S_WAIT_MOVE: begin
        if (sq_done) sq_cnt_d = sq_cnt_q - SQ_W'(1);
        if (sq_done && sq_cnt_q == SQ_W'(1)) begin
          state_d = S_RESP;
          resp_d  = RESP_ACK;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          resp_d  = RESP_TMO;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          send_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Level outputs follow the state being entered so they stay registered.
    move_go_d = (state_d == S_WAIT_MOVE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      sq_cnt_q  <= '0;
      hdg_q     <= '0;
      resp_q    <= '0;
      clr_q     <= 1'b0;
      strt_q    <= 1'b0;
      move_go_q <= 1'b0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      sq_cnt_q  <= sq_cnt_d;
      hdg_q     <= hdg_d;
      resp_q    <= resp_d;
      clr_q     <= clr_d;
      strt_q    <= strt_d;
      move_go_q <= move_go_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
    end
  end

  assign clr_cmd_rdy     = clr_q;
  assign strt_cal        = strt_q;
  assign move_go         = move_go_q;
  assign desired_heading = hdg_q;
  assign send_resp       = send_q;
  assign resp            = resp_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: directed scenarios plus randomized commands vs. a behavioural model.
module tb_cmd_dispatch;

  localparam int unsigned HS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, cal_done, sq_done, tx_busy;
  logic        strt_cal, move_go, send_resp, busy;
  logic [11:0] desired_heading;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  cmd_dispatch #(.TIMEOUT_CYCLES(24'd100), .HDG_SHIFT(HS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd             (cmd),
    .cmd_rdy         (cmd_rdy),
    .clr_cmd_rdy     (clr_cmd_rdy),
    .cal_done        (cal_done),
    .sq_done         (sq_done),
    .tx_busy         (tx_busy),
    .strt_cal        (strt_cal),
    .move_go         (move_go),
    .desired_heading (desired_heading),
    .send_resp       (send_resp),
    .resp            (resp),
    .busy            (busy)
  );

  int          checks = 0;
  int          failures = 0;
  int          send_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [11:0] exp_hdg = 12'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: response code and heading derived from the command word.
  function automatic logic [7:0] model_resp(input logic [15:0] c);
    if (c[15:12] == 4'h0 || c[15:12] == 4'h2) return 8'hA5;
    return 8'hEE;
  endfunction

  function automatic logic [11:0] model_hdg(input logic [15:0] c);
    int unsigned v;
    v = (32'(c[11:4]) * (32'd1 << HS)) % 32'd4096;
    return 12'(v);
  endfunction

  // Monitor: every send_resp pops the oldest expected response.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (send_resp === 1'b1) begin
        send_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=%0h required=none", resp);
        end else begin
          e = exp_q.pop_front();
          chk("resp", 32'(resp), 32'(e));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic issue(input logic [15:0] c, output bit ok);
    cmd     = c;
    cmd_rdy = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clr_cmd_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_rdy = 1'b0;
    chk("clr_cmd_rdy_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_send(input int hold);
    int early;
    bit found;
    early = 0;
    found = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        if (send_resp === 1'b1) early++;
      end
      chk("no_send_while_busy", 32'(early), 32'd0);
      tx_busy = 1'b0;
      tick();
      chk("send_after_busy_drop", 32'(send_resp), 32'd1);
    end else begin
      for (int i = 0; i < 40; i++) begin
        tick();
        if (send_resp === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("send_seen", 32'(found), 32'd1);
    end
    chk("busy_at_send", 32'(busy), 32'd0);
    chk("heading_hold", 32'(desired_heading), 32'(exp_hdg));
    tick();
    chk("send_one_pulse", 32'(send_resp), 32'd0);
  endtask

  task automatic do_cmd(input logic [15:0] c, input int gap_max, input int hold, input int cal_wait);
    bit ok;
    int extra;
    int n;
    int g;
    exp_q.push_back(model_resp(c));
    tx_busy = (hold > 0);
    issue(c, ok);
    if (c[15:12] == 4'h0) begin
      tick();
      chk("strt_cal_pulse", 32'(strt_cal), 32'd1);
      extra = 0;
      for (int i = 0; i < cal_wait; i++) begin
        sq_done = 1'($urandom_range(0, 1));
        tick();
        if (strt_cal === 1'b1) extra++;
        if (move_go === 1'b1) extra++;
      end
      sq_done  = 1'b0;
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      chk("cal_single_strt_no_move", 32'(extra), 32'd0);
    end else if (c[15:12] == 4'h2) begin
      n = int'(c[3:0]);
      exp_hdg = model_hdg(c);
      tick();
      chk("heading_decode", 32'(desired_heading), 32'(exp_hdg));
      chk("move_go_start", 32'(move_go), 32'(n != 0));
      for (int k = 0; k < n; k++) begin
        g = $urandom_range(0, gap_max);
        for (int j = 0; j < g; j++) begin
          cal_done = 1'($urandom_range(0, 1));
          tick();
          chk("move_go_hold", 32'(move_go), 32'd1);
        end
        cal_done = 1'b0;
        sq_done  = 1'b1;
        tick();
        sq_done  = 1'b0;
        chk("move_go_after_sq", 32'(move_go), 32'(k != n - 1));
      end
    end
    wait_send(hold);
  endtask

  // Illegal or zero-square command with tx_busy low: send_resp three cycles after cmd_rdy.
  task automatic latency(input logic [15:0] c);
    exp_q.push_back(model_resp(c));
    if (c[15:12] == 4'h2) exp_hdg = model_hdg(c);
    tx_busy = 1'b0;
    cmd     = c;
    cmd_rdy = 1'b1;
    tick();
    chk("lat_clr", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    tick();
    chk("lat_no_send_c2", 32'(send_resp), 32'd0);
    chk("lat_no_move_go", 32'(move_go), 32'd0);
    tick();
    chk("lat_send_c3", 32'(send_resp), 32'd1);
    tick();
  endtask

  initial begin
    bit ok;
    int clr_early;
    int s0;
    logic [15:0] rc;
    logic [3:0]  op;

    rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; cal_done = 1'b0; sq_done = 1'b0; tx_busy = 1'b0;
    repeat (3) tick();
    chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
    chk("rst_strt", 32'(strt_cal), 32'd0);
    chk("rst_move_go", 32'(move_go), 32'd0);
    chk("rst_send", 32'(send_resp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_heading", 32'(desired_heading), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_cmd(16'h0000, 0, 0, 20);
    do_cmd(16'h2403, 2, 0, 0);
    chk("hdg_2403", 32'(desired_heading), 32'h400);
    latency(16'h2100);
    latency(16'h7123);
    do_cmd(16'h7123, 0, 50, 0);
    do_cmd(16'h0abc, 0, 50, 5);

    // Second command arrives while a move is in progress.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hEE);
    exp_hdg = model_hdg(16'h2402);
    issue(16'h2402, ok);
    tick();
    cmd = 16'h7555;
    cmd_rdy = 1'b1;
    clr_early = 0;
    for (int k = 0; k < 2; k++) begin
      repeat (2) begin
        tick();
        if (clr_cmd_rdy === 1'b1) clr_early++;
      end
      sq_done = 1'b1;
      tick();
      sq_done = 1'b0;
      if (clr_cmd_rdy === 1'b1) clr_early++;
    end
    tick();
    chk("pend_first_send", 32'(send_resp), 32'd1);
    if (clr_cmd_rdy === 1'b1) clr_early++;
    chk("pend_no_clr_early", 32'(clr_early), 32'd0);
    tick();
    chk("pend_clr_from_idle", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    wait_send(0);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0: rc = {4'h0, 12'($urandom)};
        1: rc = {4'h2, 8'($urandom), 4'($urandom_range(0, 4))};
        default: begin
          op = 4'($urandom_range(1, 15));
          if (op == 4'h2) op = 4'hF;
          rc = {op, 12'($urandom)};
        end
      endcase
      do_cmd(rc, 3, $urandom_range(0, 3), $urandom_range(0, 25));
    end

    // Reset in the middle of a move abandons it without a response.
    issue(16'h2505, ok);
    tick();
    chk("mid_move_go", 32'(move_go), 32'd1);
    s0 = send_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_move_go_fall", 32'(move_go), 32'd0);
    chk("async_busy_fall", 32'(busy), 32'd0);
    chk("async_heading_clear", 32'(desired_heading), 32'd0);
    chk("async_resp_clear", 32'(resp), 32'd0);
    exp_hdg = 12'h000;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sq_done  = 1'($urandom_range(0, 1));
      cal_done = 1'($urandom_range(0, 1));
      tick();
    end
    sq_done = 1'b0;
    cal_done = 1'b0;
    tick();
    chk("rst_no_send", 32'(send_cnt - s0), 32'd0);
    chk("idle_move_go_low", 32'(move_go), 32'd0);

`ifdef CMD_TIMEOUT_EN
    // Move with no squares reported expires after TIMEOUT_CYCLES in the wait state.
    exp_q.push_back(8'hDD);
    exp_hdg = model_hdg(16'h2401);
    tx_busy = 1'b0;
    issue(16'h2401, ok);
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 100) chk("tmo_move_go_before", 32'(move_go), 32'd1);
      if (i == 101) chk("tmo_move_go_drop", 32'(move_go), 32'd0);
    end
    tick();
    chk("tmo_send", 32'(send_resp), 32'd1);
    tick();
`endif

    repeat (5) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
